// File: rtl/cla_seq_controller.sv
// Sequential adder: adds one N-bit chunk per clock through a single carry-lookahead
// slice, then publishes sum/cout/overflow together on a one-cycle done pulse.
module cla_seq_controller #(
  parameter int N      = 4,
  parameter int CHUNKS = 4,
  localparam int W     = N * CHUNKS
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         cin,
  output logic         busy,
  output logic         done,
  output logic [W-1:0] sum,
  output logic         cout,
  output logic         overflow
);

  localparam int IW = (CHUNKS > 1) ? $clog2(CHUNKS) : 1;

  typedef enum logic [1:0] {IDLE, ADD, DONE} state_t;

  state_t                   state_q, state_d;
  logic [CHUNKS-1:0][N-1:0] a_q, a_d, b_q, b_d, work_q, work_d;
  logic [IW-1:0]            idx_q, idx_d;
  logic                     carry_q, carry_d;
  logic [W-1:0]             sum_q, sum_d;
  logic                     cout_q, cout_d, ovf_q, ovf_d;

  logic [N-1:0] g, p;
  logic [N:0]   c;

  // Every carry is a flat sum of products over g, p and the chunk carry-in;
  // no carry feeds the next one, so depth stays constant in N.
  function automatic logic [N:0] cla(input logic [N-1:0] gi, input logic [N-1:0] pi,
                                     input logic c0);
    logic [N:0] cc;
    logic       term;
    cc    = '0;
    cc[0] = c0;
    for (int i = 0; i < N; i++) begin
      term = c0;
      for (int k = 0; k <= i; k++) term = term & pi[k];
      cc[i+1] = term;
      for (int j = 0; j <= i; j++) begin
        term = gi[j];
        for (int k = j + 1; k <= i; k++) term = term & pi[k];
        cc[i+1] = cc[i+1] | term;
      end
    end
    return cc;
  endfunction

  always_comb begin
    g = a_q[idx_q] & b_q[idx_q];
    p = a_q[idx_q] ^ b_q[idx_q];
    c = cla(g, p, carry_q);
  end

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    work_d  = work_q;
    idx_d   = idx_q;
    carry_d = carry_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          a_d     = a;
          b_d     = b;
          carry_d = cin;
          idx_d   = '0;
          work_d  = '0;
          state_d = ADD;
        end
      end
      ADD: begin
        work_d[idx_q] = p ^ c[N-1:0];
        carry_d       = c[N];
        idx_d         = idx_q + IW'(1);
        if (idx_q == IW'(CHUNKS - 1)) begin
          sum_d   = work_d;
          cout_d  = c[N];
          ovf_d   = c[N] ^ c[N-1];
          state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      work_q  <= '0;
      idx_q   <= '0;
      carry_q <= 1'b0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      work_q  <= work_d;
      idx_q   <= idx_d;
      carry_q <= carry_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
    end
  end

  assign busy     = (state_q != IDLE);
  assign done     = (state_q == DONE);
  assign sum      = sum_q;
  assign cout     = cout_q;
  assign overflow = ovf_q;

endmodule
